// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Registers the winning write, drops PC writes and flags RAW hazards.
module regfile_wb_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          v0,
  input  logic [AW-1:0] a0,
  input  logic [DW-1:0] d0,
  output logic          r0,
  input  logic          v1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic          r1,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic          WE3,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic          haz1,
  output logic          haz2,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW-1:0] PC_ADDR = {AW{1'b1}};

  logic          pri;
  logic          xfer0;
  logic          xfer1;
  logic          xfer;
  logic [AW-1:0] ga;
  logic [DW-1:0] gd;
  logic          to_pc;

  always_comb begin
    r0 = 1'b0;
    r1 = 1'b0;
    if (!reset && !hold) begin
      if (v0 && v1) begin
        r0 = ~pri;
        r1 = pri;
      end else begin
        r0 = v0;
        r1 = v1;
      end
    end
  end

  assign xfer0 = v0 & r0;
  assign xfer1 = v1 & r1;
  assign xfer  = xfer0 | xfer1;
  assign ga    = xfer1 ? a1 : a0;
  assign gd    = xfer1 ? d1 : d0;
  assign to_pc = (ga == PC_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      pri      <= 1'b0;
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      drop_cnt <= '0;
    end else begin
      WE3 <= xfer & ~to_pc;
      if (xfer) begin
        // Winner yields priority to the other requester.
        pri <= xfer0;
        if (!to_pc) begin
          A3  <= ga;
          WD3 <= gd;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  assign haz1 = WE3 & (A1 == A3);
  assign haz2 = WE3 & (A2 == A3);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants, write issue,
// hold, PC drop saturation, hazards and reset during a write.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hold = 1'b0;
  logic       v0 = 1'b0;
  logic [2:0] a0 = '0;
  logic [7:0] d0 = '0;
  logic       r0;
  logic       v1 = 1'b0;
  logic [2:0] a1 = '0;
  logic [7:0] d1 = '0;
  logic       r1;
  logic [2:0] A1 = '0;
  logic [2:0] A2 = '0;
  logic       WE3;
  logic [2:0] A3;
  logic [7:0] WD3;
  logic       haz1;
  logic       haz2;
  logic [7:0] drop_cnt;

  int vecs = 0;
  int errs = 0;

  regfile_wb_arbiter #(.DW(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .A1(A1), .A2(A2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .haz1(haz1), .haz2(haz2), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; hold = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    v0 = 0; v1 = 0; hold = 0; A1 = 0; A2 = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
    vecs++; if (WE3 !== 1'b0) begin errs++; $display("FAIL rst_we3: got %0d want 0", WE3); end
    vecs++; if (A3 !== 3'd0) begin errs++; $display("FAIL rst_a3: got %0d want 0", A3); end
    vecs++; if (WD3 !== 8'h00) begin errs++; $display("FAIL rst_wd3: got %h want 00", WD3); end
    vecs++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    vecs++; if ({r0, r1} !== 2'b00) begin errs++; $display("FAIL rst_ready: got %b want 00", {r0, r1}); end
    vecs++; if ({haz1, haz2} !== 2'b00) begin errs++; $display("FAIL rst_haz: got %b want 00", {haz1, haz2}); end
  endtask

  task automatic test_single();
    v0 = 1; a0 = 3'd3; d0 = 8'h5A;
    #1;
    vecs++; if ({r0, r1} !== 2'b10) begin errs++; $display("FAIL single_ready: got %b want 10", {r0, r1}); end
    tick();
    v0 = 0;
    vecs++; if (WE3 !== 1'b1) begin errs++; $display("FAIL single_we3: got %0d want 1", WE3); end
    vecs++; if (A3 !== 3'd3) begin errs++; $display("FAIL single_a3: got %0d want 3", A3); end
    vecs++; if (WD3 !== 8'h5A) begin errs++; $display("FAIL single_wd3: got %h want 5a", WD3); end
    tick();
    vecs++; if (WE3 !== 1'b0) begin errs++; $display("FAIL single_we3_off: got %0d want 0", WE3); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_r;
    logic [2:0] exp_a;
    logic [7:0] exp_d;
    do_reset();
    v0 = 1; a0 = 3'd1; d0 = 8'h10;
    v1 = 1; a1 = 3'd2; d1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      exp_r = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_a = (k % 2 == 0) ? 3'd1 : 3'd2;
      exp_d = (k % 2 == 0) ? 8'h10 : 8'h20;
      #1;
      vecs++; if ({r0, r1} !== exp_r) begin errs++; $display("FAIL cont_grant%0d: got %b want %b", k, {r0, r1}, exp_r); end
      tick();
      vecs++; if (WE3 !== 1'b1) begin errs++; $display("FAIL cont_we3_%0d: got %0d want 1", k, WE3); end
      vecs++; if (A3 !== exp_a) begin errs++; $display("FAIL cont_a3_%0d: got %0d want %0d", k, A3, exp_a); end
      vecs++; if (WD3 !== exp_d) begin errs++; $display("FAIL cont_wd3_%0d: got %h want %h", k, WD3, exp_d); end
    end
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_hold();
    hold = 1; v1 = 1; a1 = 3'd5; d1 = 8'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (r1 !== 1'b0) begin errs++; $display("FAIL hold_r1_%0d: got %0d want 0", k, r1); end
      tick();
      vecs++; if (WE3 !== 1'b0) begin errs++; $display("FAIL hold_we3_%0d: got %0d want 0", k, WE3); end
    end
    hold = 0;
    #1;
    vecs++; if (r1 !== 1'b1) begin errs++; $display("FAIL hold_release_r1: got %0d want 1", r1); end
    tick();
    v1 = 0;
    vecs++; if (WE3 !== 1'b1) begin errs++; $display("FAIL hold_we3_after: got %0d want 1", WE3); end
    vecs++; if (A3 !== 3'd5) begin errs++; $display("FAIL hold_a3: got %0d want 5", A3); end
    // Requester 0 transfers, so priority moves to requester 1.
    v0 = 1; a0 = 3'd2; d0 = 8'h44;
    tick();
    v0 = 0;
    hold = 1; v0 = 1; v1 = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vecs++; if ({r0, r1} !== 2'b00) begin errs++; $display("FAIL hold_both_%0d: got %b want 00", k, {r0, r1}); end
      tick();
    end
    hold = 0;
    #1;
    vecs++; if ({r0, r1} !== 2'b01) begin errs++; $display("FAIL hold_pri_kept: got %b want 01", {r0, r1}); end
    tick();
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_pc_drop();
    int exp_cnt;
    do_reset();
    v0 = 1; a0 = 3'd7; d0 = 8'hEE; A1 = 3'd7; A2 = 3'd0;
    for (int i = 0; i < 257; i++) begin
      #1;
      vecs++; if (r0 !== 1'b1) begin errs++; $display("FAIL pc_r0_%0d: got %0d want 1", i, r0); end
      tick();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      vecs++; if (WE3 !== 1'b0) begin errs++; $display("FAIL pc_we3_%0d: got %0d want 0", i, WE3); end
      vecs++; if (haz1 !== 1'b0) begin errs++; $display("FAIL pc_haz1_%0d: got %0d want 0", i, haz1); end
      vecs++; if (drop_cnt !== exp_cnt[7:0]) begin errs++; $display("FAIL pc_cnt_%0d: got %0d want %0d", i, drop_cnt, exp_cnt); end
    end
    v0 = 0;
    tick();
    vecs++; if (drop_cnt !== 8'd255) begin errs++; $display("FAIL pc_cnt_final: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_hazard();
    v0 = 1; a0 = 3'd6; d0 = 8'h11; A1 = 3'd6; A2 = 3'd5;
    #1;
    vecs++; if (haz1 !== 1'b0) begin errs++; $display("FAIL haz_pre: got %0d want 0", haz1); end
    tick();
    v0 = 0;
    vecs++; if (haz1 !== 1'b1) begin errs++; $display("FAIL haz1_hit: got %0d want 1", haz1); end
    vecs++; if (haz2 !== 1'b0) begin errs++; $display("FAIL haz2_miss: got %0d want 0", haz2); end
    vecs++; if (WD3 !== 8'h11) begin errs++; $display("FAIL haz_wd3: got %h want 11", WD3); end
    tick();
    vecs++; if ({haz1, haz2} !== 2'b00) begin errs++; $display("FAIL haz_clear: got %b want 00", {haz1, haz2}); end
    v1 = 1; a1 = 3'd5; d1 = 8'h22;
    tick();
    v1 = 0;
    vecs++; if ({haz1, haz2} !== 2'b01) begin errs++; $display("FAIL haz2_hit: got %b want 01", {haz1, haz2}); end
    tick();
  endtask

  task automatic test_reset_mid();
    v0 = 1; a0 = 3'd7;
    tick();
    a0 = 3'd4; d0 = 8'h77;
    tick();
    v0 = 0;
    vecs++; if (WE3 !== 1'b1) begin errs++; $display("FAIL mid_we3_pre: got %0d want 1", WE3); end
    reset = 1;
    tick();
    reset = 0;
    vecs++; if (WE3 !== 1'b0) begin errs++; $display("FAIL mid_we3: got %0d want 0", WE3); end
    vecs++; if (A3 !== 3'd0) begin errs++; $display("FAIL mid_a3: got %0d want 0", A3); end
    vecs++; if (WD3 !== 8'h00) begin errs++; $display("FAIL mid_wd3: got %h want 00", WD3); end
    vecs++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL mid_drop: got %0d want 0", drop_cnt); end
    v0 = 1; a0 = 3'd1; v1 = 1; a1 = 3'd2;
    #1;
    vecs++; if ({r0, r1} !== 2'b10) begin errs++; $display("FAIL mid_pri: got %b want 10", {r0, r1}); end
    tick();
    v0 = 0; v1 = 0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_pc_drop();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
